// File: rtl/addsub_pkg.sv
// Shared constants and elaboration helpers for the segmented pipelined adder/subtractor.
package addsub_pkg;

  localparam int STAGES_MIN = 1;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The top refuses to elaborate unless this holds.
  function automatic bit config_ok(input int width, input int stages);
    return (stages >= STAGES_MIN) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// One CW-bit combinational chunk of the segmented adder; also reports the carry into its top bit.
module addsub_segment #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);

  logic [CW:0] full;

  // The carry into the top bit is recovered from the sum bit: s = a ^ b ^ c_in.
  always_comb begin
    full     = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
    s        = full[CW-1:0];
    co       = full[CW];
    c_msb_in = a[CW-1] ^ b[CW-1] ^ full[CW-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Parametrised adder/subtractor split into STAGES carry segments with a valid/ready pipeline.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!config_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $fatal(1, "pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Register k holds an operation with k chunks already summed; register STAGES is the output.
  logic [WIDTH-1:0] st_sum [0:STAGES];
  logic             st_c   [0:STAGES];
  logic             st_v   [0:STAGES];
  logic [WIDTH-1:0] st_a   [0:STAGES-1];
  logic [WIDTH-1:0] st_b   [0:STAGES-1];
  logic             ovf_q;
  logic             zero_q;

  logic [CW-1:0]    seg_s   [0:STAGES-1];
  logic             seg_co  [0:STAGES-1];
  logic             seg_cm  [0:STAGES-1];
  logic [WIDTH-1:0] nxt_sum [0:STAGES-1];
  logic             adv;

  assign adv       = !st_v[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = st_v[STAGES];
  assign S         = st_sum[STAGES];
  assign Cout      = st_c[STAGES];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Unprocessed operand bits are shifted down so every segment works on the low chunk.
  for (genvar g = 0; g < STAGES; g++) begin : g_seg
    addsub_segment #(.CW(CW)) u_seg (
      .a        (st_a[g][CW-1:0]),
      .b        (st_b[g][CW-1:0]),
      .ci       (st_c[g]),
      .s        (seg_s[g]),
      .co       (seg_co[g]),
      .c_msb_in (seg_cm[g])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_sum[k]             = st_sum[k];
      nxt_sum[k][k*CW +: CW] = seg_s[k];
    end
  end

  // A stall freezes every register, bubbles included; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        st_sum[k] <= '0;
        st_c[k]   <= 1'b0;
        st_v[k]   <= 1'b0;
      end
      for (int k = 0; k < STAGES; k++) begin
        st_a[k] <= '0;
        st_b[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      st_v[0] <= in_valid;
      if (in_valid) begin
        st_a[0]   <= A;
        st_b[0]   <= (sub == SUB) ? ~B : B;
        st_c[0]   <= (sub == SUB) ? ~Cin : Cin;
        st_sum[0] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        st_v[k+1]   <= st_v[k];
        st_sum[k+1] <= nxt_sum[k];
        st_c[k+1]   <= seg_co[k];
      end
      for (int k = 0; k < STAGES-1; k++) begin
        st_a[k+1] <= st_a[k] >> CW;
        st_b[k+1] <= st_b[k] >> CW;
      end
      ovf_q  <= seg_cm[STAGES-1] ^ seg_co[STAGES-1];
      zero_q <= (nxt_sum[STAGES-1] == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed vector table plus stall, reset and random streaming scenarios for pipelined_addsub.
module tb_pipelined_addsub;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;
  logic             zero;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t        vecs [9];
  logic [18:0] exp_q [$];

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference built from signed/unsigned integer arithmetic: {cout, ovf, zero, s}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sb);
    int sa, sbv, ua, ub, ci, t;
    logic [15:0] s;
    logic cout, v;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    ua  = int'(a);
    ub  = int'(b);
    ci  = int'(cin);
    if (!sb) begin
      t    = sa + sbv + ci;
      cout = (ua + ub + ci) > 65535;
    end else begin
      t    = sa - sbv - ci;
      cout = ua >= (ub + ci);
    end
    s = t[15:0];
    v = (t > 32767) || (t < -32768);
    return {cout, v, (s == 16'h0), s};
  endfunction

  // Single op through an otherwise idle pipe: checks exact latency and all result fields.
  task automatic applyStimulus(input vec_t v, input string tag);
    in_valid  = 1'b1;
    A         = v.a;
    B         = v.b;
    Cin       = v.cin;
    sub       = v.sub;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (STAGES-1) @(posedge clk);
    #1;
    checkOutput({tag, " early_valid"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, " S"}, {16'b0, S}, {16'b0, v.s});
    checkOutput({tag, " Cout"}, {31'b0, Cout}, {31'b0, v.cout});
    checkOutput({tag, " ovf"}, {31'b0, ovf}, {31'b0, v.ovf});
    checkOutput({tag, " zero"}, {31'b0, zero}, {31'b0, v.zero});
    @(posedge clk); #1;
  endtask

  // Streaming scoreboard; stall_mode forces out_ready low in cycles 6..8, otherwise random.
  task automatic stream_ops(input int n_ops, input bit stall_mode, input string tag);
    int sent = 0, got = 0, cyc = 0, low_ready = 0;
    bit pending = 0;
    logic [15:0] held_s = '0;
    logic [18:0] exp;
    exp_q.delete();
    while ((sent < n_ops || exp_q.size() != 0) && cyc < 5000) begin
      if (stall_mode) out_ready = !(cyc >= 6 && cyc <= 8);
      else            out_ready = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        in_valid = (sent < n_ops) && (stall_mode || $urandom_range(0, 3) != 0);
        A   = 16'($urandom());
        B   = 16'($urandom());
        Cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end
      #1;
      if (!in_ready) low_ready++;
      if (stall_mode && cyc == 6) held_s = S;
      if (stall_mode && (cyc == 7 || cyc == 8))
        checkOutput({tag, " stall_hold_S"}, {16'b0, S}, {16'b0, held_s});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput({tag, " unexpected_result"}, 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          checkOutput({tag, " result"}, {13'b0, Cout, ovf, zero, S}, {13'b0, exp});
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Cin, sub));
        sent++;
        pending = 0;
      end else begin
        pending = in_valid;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput({tag, " timeout"}, {31'b0, (cyc >= 5000)}, 32'd0);
    checkOutput({tag, " result_count"}, got, n_ops);
    if (stall_mode) checkOutput({tag, " in_ready_low_cycles"}, low_ready, 32'd3);
  endtask

  initial begin
    int stale;
    vecs[0] = '{16'h6758, 16'h3241, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 16'h9D9C, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h0003, 16'h0008, 1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset outputs", {12'b0, out_valid, Cout, ovf, zero, S}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    stream_ops(8, 1'b1, "stall");

    // Three ops in flight, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = vecs[i].a; B = vecs[i].b; Cin = vecs[i].cin; sub = vecs[i].sub;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst outputs", {12'b0, out_valid, Cout, ovf, zero, S}, 32'd0);
    checkOutput("midrst in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checkOutput("midrst stale_results", stale, 32'd0);
    applyStimulus(vecs[3], "post_rst");

    stream_ops(400, 1'b0, "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
